// File: rtl/io_registers.sv
// IO register stage at 0x7000-0x7003: vblank IRQ latch, CPU read mux, serial gamepad poller.
// Latency: reads combinational; IRQ one edge after vblank_start; snapshots commit 104 edges after vblank_start at defaults.
// Backpressure: none; CPU accesses complete every cycle, and vblank_start during a poll is not queued.
// Optional feature macro: IO_REGISTERS_IRQ_OVERRUN_EN adds a sticky overrun flag at bit1 of 0x7001.
module io_registers #(
    parameter int unsigned LATCH_CYCLES = 12,
    parameter int unsigned HALF_PERIOD  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wen,
    output logic [7:0] cpu_data_out,
    input  logic       SELECT_in_vblank,
    input  logic       SELECT_clr_vblank_irq,
    input  logic       SELECT_controller_1,
    input  logic       SELECT_controller_2,
    input  logic       vblank_active,
    input  logic       vblank_start,
    output logic       irq_n,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    input  logic       ctrl_data_1,
    input  logic       ctrl_data_2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SAMPLE,
        S_CLK_HIGH,
        S_CLK_LOW
    } state_t;

    localparam logic [7:0] LATCH_INIT = 8'(LATCH_CYCLES);
    localparam logic [7:0] HALF_INIT  = 8'(HALF_PERIOD);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_1_q, shift_1_d;
    logic [7:0] shift_2_q, shift_2_d;
    logic [7:0] controller_1_q, controller_1_d;
    logic [7:0] controller_2_q, controller_2_d;
    logic       irq_pending_q, irq_pending_d;
    logic       irq_overrun_q, irq_overrun_d;
    logic       irq_clr;

    // Write data carries no meaning at this address range; only the strobe matters.
    logic unused_cpu_data;
    assign unused_cpu_data = ^cpu_data_in;

    assign irq_clr = SELECT_clr_vblank_irq & cpu_wen;

    // IRQ latch next state: a vblank_start pulse beats a simultaneous clear.
    always_comb begin
        irq_pending_d = irq_pending_q;
        irq_overrun_d = 1'b0;
        if (vblank_start) begin
            irq_pending_d = 1'b1;
        end else if (irq_clr) begin
            irq_pending_d = 1'b0;
        end
`ifdef IO_REGISTERS_IRQ_OVERRUN_EN
        // A second vblank while the first is still unacknowledged; irq_pending_q is
        // still high during a clearing write, so that case is covered too.
        irq_overrun_d = irq_overrun_q;
        if (vblank_start && irq_pending_q) begin
            irq_overrun_d = 1'b1;
        end else if (irq_clr) begin
            irq_overrun_d = 1'b0;
        end
`endif
    end

    // Poll FSM: latch pulse, then eight samples separated by one clock pulse each.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        shift_1_d      = shift_1_q;
        shift_2_d      = shift_2_q;
        controller_1_d = controller_1_q;
        controller_2_d = controller_2_q;
        case (state_q)
            S_IDLE: begin
                if (vblank_start) begin
                    state_d = S_LATCH;
                    cnt_d   = LATCH_INIT;
                end
            end
            S_LATCH: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SAMPLE: begin
                // Pads are active-low; store 1 = pressed, A ends up in bit7.
                shift_1_d = {shift_1_q[6:0], ~ctrl_data_1};
                shift_2_d = {shift_2_q[6:0], ~ctrl_data_2};
                if (idx_q == 3'd7) begin
                    controller_1_d = shift_1_d;
                    controller_2_d = shift_2_d;
                    idx_d          = 3'd0;
                    state_d        = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = HALF_INIT;
                    state_d = S_CLK_HIGH;
                end
            end
            S_CLK_HIGH: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = HALF_INIT;
                    state_d = S_CLK_LOW;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CLK_LOW: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any poll in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            idx_q          <= 3'd0;
            shift_1_q      <= 8'd0;
            shift_2_q      <= 8'd0;
            controller_1_q <= 8'h00;
            controller_2_q <= 8'h00;
            irq_pending_q  <= 1'b0;
            irq_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shift_1_q      <= shift_1_d;
            shift_2_q      <= shift_2_d;
            controller_1_q <= controller_1_d;
            controller_2_q <= controller_2_d;
            irq_pending_q  <= irq_pending_d;
            irq_overrun_q  <= irq_overrun_d;
        end
    end

    assign irq_n      = ~irq_pending_q;
    assign ctrl_latch = (state_q == S_LATCH);
    assign ctrl_clk   = (state_q == S_CLK_HIGH);

    // CPU read mux; selects are one-hot so an AND-OR needs no priority.
    always_comb begin
        cpu_data_out = 8'h00;
        if (!cpu_wen) begin
            cpu_data_out = ({8{SELECT_in_vblank}}      & {7'b0, vblank_active})
                         | ({8{SELECT_clr_vblank_irq}} & {6'b0, irq_overrun_q, irq_pending_q})
                         | ({8{SELECT_controller_1}}   & controller_1_q)
                         | ({8{SELECT_controller_2}}   & controller_2_q);
        end
    end

endmodule

// File: doc/io_registers.md
Name: io_registers

Overview:
- Memory-mapped IO register stage directly downstream of the CPU address decoder.
- Consumes the decoder's IO selects for 0x7000–0x7003 and serves CPU reads and writes there.
- Owns the vblank interrupt latch and the serial controller-polling engine.
- Samples two NES-style serial gamepads once per vblank and presents an atomic 8-bit snapshot of each to the CPU.

Parameters:
- LATCH_CYCLES, 12: cycles ctrl_latch is held high; legal range 1..255.
- HALF_PERIOD, 6: cycles per ctrl_clk high phase and per low phase; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_data_in  in  8  CPU write data
- cpu_wen  in  1  1 = CPU write this cycle, 0 = read
- cpu_data_out  out  8  read data; combinational
- SELECT_in_vblank  in  1  decoder select, 0x7000
- SELECT_clr_vblank_irq  in  1  decoder select, 0x7001
- SELECT_controller_1  in  1  decoder select, 0x7002
- SELECT_controller_2  in  1  decoder select, 0x7003
- vblank_active  in  1  level from video timing; high during vblank
- vblank_start  in  1  one-cycle pulse at vblank entry
- irq_n  out  1  active-low CPU interrupt
- ctrl_latch  out  1  controller latch strobe
- ctrl_clk  out  1  controller shift clock
- ctrl_data_1  in  1  controller 1 serial data; active-low (0 = pressed)
- ctrl_data_2  in  1  controller 2 serial data; active-low (0 = pressed)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: irq_pending=0, irq_n=1, ctrl_latch=0, ctrl_clk=0, controller_1=8'h00, controller_2=8'h00, shift registers=0, bit index=0, FSM=IDLE.
- Read mux (combinational; cpu_wen=0):
  - 0x7000 → {7'b0, vblank_active}
  - 0x7001 → {7'b0, irq_pending}
  - 0x7002 → controller_1
  - 0x7003 → controller_2
  - no select → 8'h00
  - Selects are one-hot; no priority is defined.
- Writes: only 0x7001 has an effect; data is ignored and irq_pending clears at the next edge. Writes to 0x7000, 0x7002 and 0x7003 are ignored.
- IRQ:
  - vblank_start sets irq_pending; irq_n = ~irq_pending (registered, one-cycle latency from the pulse).
  - Set and clear in the same cycle: set wins.
- Controller byte format: bit7..0 = A, B, Select, Start, Up, Down, Left, Right; 1 = pressed. Incoming ctrl_data is inverted before capture.
- Poll FSM states:
  - IDLE: vblank_start seen at edge E0 → LATCH.
  - LATCH: ctrl_latch=1 for exactly LATCH_CYCLES cycles → SAMPLE.
  - SAMPLE: one cycle. At its closing edge, capture ~ctrl_data_x, shifting left into the shift register. If bit index = 7 → commit, go IDLE. Otherwise increment index → CLK_HIGH.
  - CLK_HIGH: ctrl_clk=1 for HALF_PERIOD cycles → CLK_LOW.
  - CLK_LOW: ctrl_clk=0 for HALF_PERIOD cycles → SAMPLE.
- Capture timing:
  - Bit 0 (A) captured at edge E0+LATCH_CYCLES+1.
  - Each later bit is captured 2·HALF_PERIOD+1 edges after the previous one.
  - Commit happens at the edge that captures bit 7: E0+LATCH_CYCLES+1+7·(2·HALF_PERIOD+1), which is E0+104 at defaults.
- Atomic update: controller_1 and controller_2 both update only at commit, in the same edge. CPU reads during a poll return the previous snapshot.
- vblank_start while FSM ≠ IDLE: no restart, no queueing; it still sets irq_pending.
- Reset mid-poll: immediate return to IDLE with all reset values; the partial shift is discarded.
- Phase counter: 8-bit, counts down from the parameter value to 1; no wrap issues within the legal parameter range.

Optional Feature:
- Macro: IO_REGISTERS_IRQ_OVERRUN_EN.
- When defined:
  - Adds an irq_overrun flag, set when vblank_start arrives while irq_pending=1 (or in the same cycle irq_pending is being cleared by a 0x7001 write, since set wins).
  - 0x7001 read returns {6'b0, irq_overrun, irq_pending}.
  - A write to 0x7001 clears both flags; if set and clear coincide, set wins.
  - Reset value 0.
- When undefined: no flag; bit1 of the 0x7001 read is 0.

Test Plan:
1. Reset check: drive rst_n low mid-CLK_HIGH, then release → irq_n=1, ctrl_latch=0, ctrl_clk=0, reads of 0x7002/0x7003 = 8'h00.
2. Full poll: pulse vblank_start with ctrl_data_1 serial stream 0,1,1,1,1,1,1,0 (A and Right pressed) and ctrl_data_2 held 1 → ctrl_latch high 12 cycles; 7 ctrl_clk pulses, each 6 high / 6 low; at E0+104 controller_1=8'h81, controller_2=8'h00.
3. Atomicity: hold the previous snapshot 8'h81 and read 0x7002 at E0+50 of a new poll whose pattern produces 8'h3C → read returns 8'h81; read after E0+104 returns 8'h3C.
4. IRQ: vblank_start → irq_n=0 one cycle later, 0x7001 read = 8'h01; write 0x7001 → irq_n=1. Then pulse vblank_start in the same cycle as a 0x7001 write → irq_pending stays 1.
5. Mid-poll vblank: second vblank_start at E0+40 → poll still commits at E0+104 with no second latch pulse; irq_pending=1.
6. With IO_REGISTERS_IRQ_OVERRUN_EN: two vblank_starts with no clear between them → 0x7001 read = 8'h03; a write to 0x7001 → read = 8'h00.
